sram_ctrl: RTL
==============

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set the SRAM access cycles per transfer; legal range 2..15.
REQ-002 Parameter ADDR_W, default 20, SHALL set the SRAM word-address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 ram_ce_i  input  1  data-port request.
REQ-006 ram_we_i  input  1  data-port write (1) / read (0).
REQ-007 ram_addr_i  input  32  data-port byte address; bits [1:0] ignored.
REQ-008 ram_sel_i  input  4  data-port byte enables, active-high, bit n = byte lane n.
REQ-009 ram_data_i  input  32  data-port write data.
REQ-010 ram_data_o  output  32  data-port read data.
REQ-011 ram_ready_o  output  1  data-port completion pulse.
REQ-012 pc_ram_ce_i  input  1  fetch-port request (read only).
REQ-013 pc_ram_addr_i  input  32  fetch byte address; bits [1:0] ignored.
REQ-014 pc_ram_data_o  output  32  fetch read data.
REQ-015 pc_ram_ready_o  output  1  fetch completion pulse.
REQ-016 sram_addr_o  output  ADDR_W  word address = selected addr[ADDR_W+1:2].
REQ-017 sram_data_o  output  32  write data to SRAM.
REQ-018 sram_data_i  input  32  read data from SRAM.
REQ-019 sram_ce_n_o, sram_oe_n_o, sram_we_n_o  output  1 each  active-low strobes.
REQ-020 sram_be_n_o  output  4  active-low byte enables.

Function
REQ-021 FSM SHALL have states IDLE, ACCESS, RESP.
REQ-022 IDLE: if any ce high, SHALL grant one port, latch its addr/we/sel/wdata, load counter with WAIT_CYCLES-1, go ACCESS; else stay IDLE.
REQ-023 Arbitration: single requester wins; both requesting, grant SHALL go to the port not granted last (last_grant resets to fetch, so data wins first).
REQ-024 ACCESS: sram_ce_n_o=0, address/data/byte enables SHALL be stable from latched values for all WAIT_CYCLES cycles; counter decrements each cycle; at counter 0 go RESP.
REQ-025 Read: sram_oe_n_o=0 throughout ACCESS, sram_be_n_o=4'b0000; sram_data_i SHALL be captured on the edge leaving ACCESS.
REQ-026 Write: sram_we_n_o=0 in every ACCESS cycle except the last (hold cycle); sram_oe_n_o=1; sram_be_n_o=~ram_sel_i latched; ram_sel_i=0 SHALL still complete with no byte written.
REQ-027 RESP: exactly one cycle; granted port's ready SHALL be 1 and, for reads, its data output SHALL carry captured word; next state IDLE; all strobes deasserted.
REQ-028 Latency: request seen in IDLE at cycle 0 -> ready at cycle WAIT_CYCLES+1; back-to-back throughput one access per WAIT_CYCLES+2 cycles.
REQ-029 Requester SHALL hold ce/addr stable until its ready; a granted access SHALL always complete and pulse ready even if ce drops mid-access (no torn writes).
REQ-030 Inputs SHALL be ignored outside IDLE; changes after grant do not affect the transfer.
REQ-031 ram_data_o/pc_ram_data_o SHALL hold their last read value until next read completion on that port; writes do not change ram_data_o.
REQ-032 Both ready outputs SHALL never be high in the same cycle.

Reset
REQ-033 On rst=0, immediately: state IDLE, counter 0, last_grant=fetch, ready outputs 0, data outputs 0, sram_ce_n_o/oe_n/we_n=1, sram_be_n_o=4'hF, sram_addr_o=0, sram_data_o=0.
REQ-034 Reset during ACCESS SHALL abort the transfer with no ready pulse; first grant possible on first edge after rst rises.

Structure
REQ-035 State encodings and WAIT_CYCLES default SHALL live in the shared defines file; bus widths reuse existing RegBus definitions.
REQ-036 No sub-module; FSM, counter and arbiter are one block, outputs registered.

Verification (WAIT_CYCLES=2)
REQ-037 Fetch read addr 0x00000010, SRAM word 4 = 0x24020001 -> sram_addr_o=4 with oe_n=0 for 2 cycles, pc_ram_ready_o pulse at cycle 3 with pc_ram_data_o=0x24020001.
REQ-038 Data write addr 0x00000008, sel=4'b0010, data 0x0000AB00 -> we_n=0 1 cycle, be_n=4'b1101, word 2 byte1 becomes 0xAB, others unchanged, ram_ready_o at cycle 3.
REQ-039 Both ports request continuously -> grants alternate data, fetch, data, fetch; ready pulses 4 cycles apart, never coincident.
REQ-040 Data read started, ram_ce_i dropped at cycle 1 -> access completes, ram_ready_o still pulses at cycle 3.
REQ-041 rst=0 asserted mid-write at cycle 1 -> strobes high and we_n=1 asynchronously, no ready pulse; after release new fetch completes normally.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg -- shared definitions for the SRAM controller slice.
//   reg_bus_t        : 32-bit CPU-side register/bus word (RegBus).
//   WAIT_CYCLES_DEF  : default SRAM access cycles per transfer.
//   ST_*             : controller FSM state encodings.
//   GRANT_*          : arbiter port identifiers.
package sram_ctrl_pkg;

  localparam int REG_BUS_W = 32;
  typedef logic [REG_BUS_W-1:0] reg_bus_t;

  localparam int WAIT_CYCLES_DEF = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic GRANT_DATA  = 1'b0;
  localparam logic GRANT_FETCH = 1'b1;

  // Fetch wins when it is the only requester, or when both request and
  // the data port was the previous winner.
  function automatic logic pick_fetch(input logic data_ce, input logic fetch_ce,
                                      input logic last_grant);
    return fetch_ce && (!data_ce || (last_grant == GRANT_DATA));
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if -- CPU-side ports of the SRAM controller.
//   Data port : ram_ce_i, ram_we_i, ram_addr_i, ram_sel_i, ram_data_i -> ram_data_o, ram_ready_o
//   Fetch port: pc_ram_ce_i, pc_ram_addr_i                            -> pc_ram_data_o, pc_ram_ready_o
// Handshake: a requester raises *_ce_i and holds it plus address/data stable
// until its *_ready_o pulses high for exactly one cycle. Once the controller
// has granted a request it completes it even if *_ce_i is withdrawn; read data
// is valid on the ready cycle and held until that port's next read completes.
// Modport master = CPU side, slave = controller side.
interface sram_ctrl_if;
  import sram_ctrl_pkg::*;

  logic     ram_ce_i;
  logic     ram_we_i;
  reg_bus_t ram_addr_i;
  logic [3:0] ram_sel_i;
  reg_bus_t ram_data_i;
  reg_bus_t ram_data_o;
  logic     ram_ready_o;

  logic     pc_ram_ce_i;
  reg_bus_t pc_ram_addr_i;
  reg_bus_t pc_ram_data_o;
  logic     pc_ram_ready_o;

  modport master (
    output ram_ce_i, ram_we_i, ram_addr_i, ram_sel_i, ram_data_i,
    output pc_ram_ce_i, pc_ram_addr_i,
    input  ram_data_o, ram_ready_o, pc_ram_data_o, pc_ram_ready_o
  );

  modport slave (
    input  ram_ce_i, ram_we_i, ram_addr_i, ram_sel_i, ram_data_i,
    input  pc_ram_ce_i, pc_ram_addr_i,
    output ram_data_o, ram_ready_o, pc_ram_data_o, pc_ram_ready_o
  );

endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl -- two-port (data + instruction fetch) asynchronous SRAM controller.
// One FSM (IDLE -> ACCESS -> RESP) with a built-in round-robin arbiter and
// wait counter; every output is registered.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   bus             : sram_ctrl_if.slave, CPU data and fetch ports
//   sram_addr_o     : SRAM word address (byte address bits [ADDR_W+1:2])
//   sram_data_o/_i  : SRAM write / read data
//   sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o : active-low strobes
//   o_dbg_state     : current FSM state (ST_* encoding)
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  sram_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] sram_addr_o,
  output reg_bus_t          sram_data_o,
  input  reg_bus_t          sram_data_i,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o,
  output logic [1:0]        o_dbg_state
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_last_grant;
  logic              r_grant;
  logic              r_is_write;
  logic [ADDR_W-1:0] r_sram_addr;
  reg_bus_t          r_sram_wdata;
  logic              r_sram_ce_n;
  logic              r_sram_oe_n;
  logic              r_sram_we_n;
  logic [3:0]        r_sram_be_n;
  reg_bus_t          r_ram_data;
  reg_bus_t          r_pc_data;
  logic              r_ram_ready;
  logic              r_pc_ready;

  logic w_any_req;
  logic w_grant_fetch;
  logic w_unused_addr_bits;

  assign w_any_req     = bus.ram_ce_i || bus.pc_ram_ce_i;
  assign w_grant_fetch = pick_fetch(bus.ram_ce_i, bus.pc_ram_ce_i, r_last_grant);

  // Byte-offset and out-of-range address bits carry no meaning here.
  assign w_unused_addr_bits = ^{bus.ram_addr_i[1:0], bus.ram_addr_i[31:ADDR_W+2],
                                bus.pc_ram_addr_i[1:0], bus.pc_ram_addr_i[31:ADDR_W+2]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_grant <= GRANT_FETCH;
      r_grant      <= GRANT_DATA;
      r_is_write   <= 1'b0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_sram_ce_n  <= 1'b1;
      r_sram_oe_n  <= 1'b1;
      r_sram_we_n  <= 1'b1;
      r_sram_be_n  <= 4'hF;
      r_ram_data   <= '0;
      r_pc_data    <= '0;
      r_ram_ready  <= 1'b0;
      r_pc_ready   <= 1'b0;
    end else begin
      // Ready is a single-cycle pulse: cleared unless set below.
      r_ram_ready <= 1'b0;
      r_pc_ready  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_grant      <= w_grant_fetch ? GRANT_FETCH : GRANT_DATA;
            r_last_grant <= w_grant_fetch ? GRANT_FETCH : GRANT_DATA;
            r_cnt        <= CNT_LOAD;
            r_sram_ce_n  <= 1'b0;
            r_state      <= ST_ACCESS;
            if (w_grant_fetch) begin
              r_is_write  <= 1'b0;
              r_sram_addr <= bus.pc_ram_addr_i[ADDR_W+1:2];
              r_sram_oe_n <= 1'b0;
              r_sram_we_n <= 1'b1;
              r_sram_be_n <= 4'h0;
            end else begin
              r_is_write  <= bus.ram_we_i;
              r_sram_addr <= bus.ram_addr_i[ADDR_W+1:2];
              if (bus.ram_we_i) begin
                r_sram_wdata <= bus.ram_data_i;
                r_sram_oe_n  <= 1'b1;
                r_sram_we_n  <= 1'b0;
                r_sram_be_n  <= ~bus.ram_sel_i;
              end else begin
                r_sram_oe_n  <= 1'b0;
                r_sram_we_n  <= 1'b1;
                r_sram_be_n  <= 4'h0;
              end
            end
          end
        end
        ST_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state     <= ST_RESP;
            r_sram_ce_n <= 1'b1;
            r_sram_oe_n <= 1'b1;
            r_sram_we_n <= 1'b1;
            r_sram_be_n <= 4'hF;
            if (r_grant == GRANT_FETCH) begin
              r_pc_ready <= 1'b1;
              r_pc_data  <= sram_data_i;
            end else begin
              r_ram_ready <= 1'b1;
              if (!r_is_write) r_ram_data <= sram_data_i;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
            // Release we_n one cycle early so address/data are held past
            // the write strobe's rising edge.
            if (r_cnt == 4'd1) r_sram_we_n <= 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sram_addr_o        = r_sram_addr;
  assign sram_data_o        = r_sram_wdata;
  assign sram_ce_n_o        = r_sram_ce_n;
  assign sram_oe_n_o        = r_sram_oe_n;
  assign sram_we_n_o        = r_sram_we_n;
  assign sram_be_n_o        = r_sram_be_n;
  assign bus.ram_data_o     = r_ram_data;
  assign bus.ram_ready_o    = r_ram_ready;
  assign bus.pc_ram_data_o  = r_pc_data;
  assign bus.pc_ram_ready_o = r_pc_ready;
  assign o_dbg_state        = r_state;

endmodule
